// File: rtl/slv_guard_rst_ctrl_if.sv
// Reset-sequencer bundle between the subordinate guard (master side) and
// slv_guard_rst_ctrl (slave side). The guard drives the request and the
// counter clear. The sequencer returns the status strobe, the subordinate
// reset, the isolation/busy flags, the reset count and the error flag.
interface slv_guard_rst_ctrl_if #(
  parameter int CntWidth = 8
);
  logic                rst_req_i;
  logic                clr_cnt_i;
  logic                rst_stat_o;
  logic                slv_rst_no;
  logic                isolate_o;
  logic                busy_o;
  logic [CntWidth-1:0] rst_cnt_o;
  logic                err_o;

  modport master (
    output rst_req_i,
    output clr_cnt_i,
    input  rst_stat_o,
    input  slv_rst_no,
    input  isolate_o,
    input  busy_o,
    input  rst_cnt_o,
    input  err_o
  );

  modport slave (
    input  rst_req_i,
    input  clr_cnt_i,
    output rst_stat_o,
    output slv_rst_no,
    output isolate_o,
    output busy_o,
    output rst_cnt_o,
    output err_o
  );
endinterface

// File: rtl/slv_guard_rst_ctrl.sv
// Subordinate reset sequencer placed downstream of the subordinate guard.
// A guard reset request produces a fixed-length active-low reset pulse into
// the subordinate, followed by a settle interval and a one-cycle completion
// strobe back to the guard. The sequencer then waits for the request to drop.
// Optional build macro SLV_GUARD_RST_TIMEOUT_EN bounds the wait for the
// request to drop. When that wait expires, the sticky err_o is set and the
// FSM is forced back to IDLE. Without the macro, err_o is tied low.
module slv_guard_rst_ctrl #(
  parameter int RstCycles     = 16,
  parameter int SettleCycles  = 8,
  parameter int TimeoutCycles = 256,
  parameter int CntWidth      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  slv_guard_rst_ctrl_if.slave   bus
);

  localparam int MaxRs   = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
  localparam int MaxPh   = (MaxRs > TimeoutCycles) ? MaxRs : TimeoutCycles;
  localparam int PhW     = $clog2(MaxPh + 1);
  localparam logic [PhW-1:0] RstLd    = PhW'(RstCycles);
  localparam logic [PhW-1:0] SettleLd = PhW'(SettleCycles);
  localparam logic [PhW-1:0] PhOne    = PhW'(1);
`ifdef SLV_GUARD_RST_TIMEOUT_EN
  localparam logic [PhW-1:0] TmoLd    = PhW'(TimeoutCycles);
`endif
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  typedef enum logic [2:0] {
    INIT, IDLE, ASSERT, SETTLE, ACK, WAIT_CLR
  } state_e;

  typedef struct packed {
    logic slv_rst_n;
    logic isolate;
    logic busy;
    logic stat;
  } outs_t;

  // Registered output pattern for the state being entered.
  function automatic outs_t outs_for(input state_e s);
    outs_t o;
    o = '{slv_rst_n: 1'b1, isolate: 1'b1, busy: 1'b1, stat: 1'b0};
    case (s)
      INIT:    o.slv_rst_n = 1'b0;
      IDLE:    begin o.isolate = 1'b0; o.busy = 1'b0; end
      ASSERT:  o.slv_rst_n = 1'b0;
      ACK:     o.stat = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  state_e              state_q;
  logic [PhW-1:0]      ph_q;
  outs_t               outs_q;
  logic [CntWidth-1:0] cnt_q;
`ifdef SLV_GUARD_RST_TIMEOUT_EN
  logic                err_q;
`endif

  // Sequencer FSM: phase counter loaded on every state entry, counts down
  // to 1. Outputs are registered from the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      ph_q    <= RstLd;
      outs_q  <= outs_for(INIT);
      cnt_q   <= '0;
`ifdef SLV_GUARD_RST_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // Clear beats a same-cycle increment.
      if (bus.clr_cnt_i) cnt_q <= '0;
      case (state_q)
        INIT: begin
          if (ph_q == PhOne) begin
            state_q <= IDLE;
            outs_q  <= outs_for(IDLE);
          end else begin
            ph_q <= ph_q - PhOne;
          end
        end
        IDLE: begin
          if (bus.rst_req_i) begin
            state_q <= ASSERT;
            ph_q    <= RstLd;
            outs_q  <= outs_for(ASSERT);
            if (!bus.clr_cnt_i && cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
          end
        end
        ASSERT: begin
          if (ph_q == PhOne) begin
            if (SettleCycles == 0) begin
              state_q <= ACK;
              outs_q  <= outs_for(ACK);
            end else begin
              state_q <= SETTLE;
              ph_q    <= SettleLd;
              outs_q  <= outs_for(SETTLE);
            end
          end else begin
            ph_q <= ph_q - PhOne;
          end
        end
        SETTLE: begin
          if (ph_q == PhOne) begin
            state_q <= ACK;
            outs_q  <= outs_for(ACK);
          end else begin
            ph_q <= ph_q - PhOne;
          end
        end
        ACK: begin
          state_q <= WAIT_CLR;
          outs_q  <= outs_for(WAIT_CLR);
`ifdef SLV_GUARD_RST_TIMEOUT_EN
          ph_q    <= TmoLd;
`endif
        end
        WAIT_CLR: begin
          if (!bus.rst_req_i) begin
            state_q <= IDLE;
            outs_q  <= outs_for(IDLE);
`ifdef SLV_GUARD_RST_TIMEOUT_EN
          end else if (ph_q == PhOne) begin
            // Guard never dropped its request: flag it and rearm from IDLE.
            state_q <= IDLE;
            outs_q  <= outs_for(IDLE);
            err_q   <= 1'b1;
          end else begin
            ph_q <= ph_q - PhOne;
`endif
          end
        end
        default: begin
          state_q <= INIT;
          ph_q    <= RstLd;
          outs_q  <= outs_for(INIT);
        end
      endcase
    end
  end

  assign bus.slv_rst_no = outs_q.slv_rst_n;
  assign bus.isolate_o  = outs_q.isolate;
  assign bus.busy_o     = outs_q.busy;
  assign bus.rst_stat_o = outs_q.stat;
  assign bus.rst_cnt_o  = cnt_q;
`ifdef SLV_GUARD_RST_TIMEOUT_EN
  assign bus.err_o      = err_q;
`else
  assign bus.err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Bench for slv_guard_rst_ctrl: two instances (settle 8 / 8-bit count and
// settle 0 / 2-bit count) share one stimulus/observe path selected by sel.
// Expected completion strobes are queued when a request is driven.
module tb_slv_guard_rst_ctrl;
  localparam int R_CYC = 16;
  localparam int S_A   = 8;
  localparam int S_B   = 0;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic req = 1'b0, clr = 1'b0, sel = 1'b0;
  int vectors = 0, miscompares = 0;
  int cnt_a = 0, cnt_b = 0, exp_cnt = 0;

  typedef struct {
    int stat_cyc;
    int cnt;
  } exp_t;
  exp_t sb[$];

  slv_guard_rst_ctrl_if #(.CntWidth(8)) if_a ();
  slv_guard_rst_ctrl_if #(.CntWidth(2)) if_b ();

  assign if_a.rst_req_i = req & ~sel;
  assign if_a.clr_cnt_i = clr & ~sel;
  assign if_b.rst_req_i = req & sel;
  assign if_b.clr_cnt_i = clr & sel;

  slv_guard_rst_ctrl #(.RstCycles(R_CYC), .SettleCycles(S_A), .TimeoutCycles(TMO), .CntWidth(8))
    dut_a (.clk_i(clk), .rst_ni(rst_ni), .bus(if_a));
  slv_guard_rst_ctrl #(.RstCycles(R_CYC), .SettleCycles(S_B), .TimeoutCycles(TMO), .CntWidth(2))
    dut_b (.clk_i(clk), .rst_ni(rst_ni), .bus(if_b));

  logic       obs_slv, obs_iso, obs_busy, obs_stat, obs_err;
  logic [7:0] obs_cnt;
  assign obs_slv  = sel ? if_b.slv_rst_no : if_a.slv_rst_no;
  assign obs_iso  = sel ? if_b.isolate_o  : if_a.isolate_o;
  assign obs_busy = sel ? if_b.busy_o     : if_a.busy_o;
  assign obs_stat = sel ? if_b.rst_stat_o : if_a.rst_stat_o;
  assign obs_err  = sel ? if_b.err_o      : if_a.err_o;
  assign obs_cnt  = sel ? {6'b0, if_b.rst_cnt_o} : if_a.rst_cnt_o;

  task automatic check(input string tag, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard consumer: every completion strobe must match a queued request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && obs_stat) begin
      if (sb.size() == 0) begin
        check("stat_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        check("stat_cyc", cyc, e.stat_cyc);
        check("stat_cnt", obs_cnt, e.cnt);
      end
    end
  end

  // Drive a request into an idle sequencer and queue its expected strobe.
  task automatic start_req(input bit with_clr, output int n);
    int s_cur;
    check("idle_before_req", obs_busy, 0);
    n = cyc;
    req = 1'b1;
    clr = with_clr;
    if (sel) begin
      cnt_b = with_clr ? 0 : ((cnt_b == 3) ? 3 : cnt_b + 1);
      exp_cnt = cnt_b;
      s_cur = S_B;
    end else begin
      cnt_a = with_clr ? 0 : ((cnt_a == 255) ? 255 : cnt_a + 1);
      exp_cnt = cnt_a;
      s_cur = S_A;
    end
    sb.push_back('{n + 1 + R_CYC + s_cur, exp_cnt});
  endtask

  // Follow a sequence up to its strobe, measuring the reset pulse length.
  task automatic track(input int n, input bit drop_early, output int s);
    int lo;
    step();
    clr = 1'b0;
    check("assert_cyc", cyc, n + 1);
    check("assert_slv_rst", obs_slv, 0);
    check("assert_isolate", obs_iso, 1);
    check("cnt_inc", obs_cnt, exp_cnt);
    if (drop_early) req = 1'b0;
    lo = 1;
    s = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (obs_stat) begin
        s = cyc;
        break;
      end
      if (!obs_slv) lo++;
    end
    check("rst_len", lo, R_CYC);
    if (s < 0) check("stat_seen", 0, 1);
  endtask

  // Drop the request one cycle after the strobe and expect IDLE a cycle later.
  task automatic finish_seq();
    step();
    check("wait_clr_isolate", obs_iso, 1);
    check("wait_clr_busy", obs_busy, 1);
    req = 1'b0;
    step();
    check("idle_isolate", obs_iso, 0);
    check("idle_busy", obs_busy, 0);
    check("idle_slv_rst", obs_slv, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, lo;
    repeat (3) step();
    check("rst_slv_rst", obs_slv, 0);
    check("rst_isolate", obs_iso, 1);
    check("rst_busy", obs_busy, 1);
    check("rst_stat", obs_stat, 0);
    check("rst_cnt", obs_cnt, 0);
    check("rst_err", obs_err, 0);

    // Power-up: INIT holds the subordinate in reset for R_CYC cycles.
    rst_ni = 1'b1;
    lo = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (obs_slv) break;
      lo++;
    end
    check("init_len", lo, R_CYC);
    check("init_busy", obs_busy, 0);
    check("init_isolate", obs_iso, 0);
    check("init_cnt", obs_cnt, 0);
    repeat (5) step();

    // Settle 8, request held until one cycle after the strobe.
    start_req(1'b0, n);
    track(n, 1'b0, s);
    finish_seq();

    // Single-cycle request pulse still yields a full sequence.
    start_req(1'b0, n);
    track(n, 1'b1, s);
    finish_seq();

    // Settle 0 and counter saturation at 3 on the 2-bit instance.
    sel = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      start_req(1'b0, n);
      track(n, (k % 2) == 0, s);
      finish_seq();
    end
    check("cnt_saturated", obs_cnt, 3);

    // Clear on the increment cycle wins.
    start_req(1'b1, n);
    track(n, 1'b1, s);
    finish_seq();
    check("cnt_after_clr", obs_cnt, 0);

    // Request held through WAIT_CLR.
    sel = 1'b0;
    step();
    start_req(1'b0, n);
    track(n, 1'b0, s);
    step();
`ifdef SLV_GUARD_RST_TIMEOUT_EN
    check("err_pre", obs_err, 0);
    repeat (TMO - 1) step();
    check("tmo_wait_busy", obs_busy, 1);
    check("err_pre_expiry", obs_err, 0);
    step();
    check("err_set", obs_err, 1);
    start_req(1'b0, n);
    track(n, 1'b1, s);
    finish_seq();
    check("err_sticky", obs_err, 1);
`else
    repeat (20) step();
    check("wait_hold_busy", obs_busy, 1);
    check("wait_hold_isolate", obs_iso, 1);
    check("err_tied", obs_err, 0);
    req = 1'b0;
    step();
    check("wait_release_busy", obs_busy, 0);
`endif
    check("sb_empty", sb.size(), 0);

    // Reset mid-sequence returns to reset values at once.
    start_req(1'b0, n);
    repeat (3) step();
    rst_ni = 1'b0;
    #1;
    check("midrst_slv_rst", obs_slv, 0);
    check("midrst_isolate", obs_iso, 1);
    check("midrst_busy", obs_busy, 1);
    check("midrst_cnt", obs_cnt, 0);
    check("midrst_err", obs_err, 0);
    sb.delete();
    req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
